// File: rtl/lzss_frame_ctrl.sv
// lzss_frame_ctrl: sequences one LZSS encoder frame by frame and buffers its tokens.
// Optional per-frame token statistics are enabled by defining LZSS_FRAME_CTRL_STATS_EN.
module lzss_frame_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 enc_rst_n,
    output logic                 enc_w_en,
    output logic [WORD_SIZE-1:0] enc_data,
    input  logic [WORD_SIZE:0]   enc_tok,
    input  logic                 enc_tok_vld,
    output logic [WORD_SIZE:0]   m_tok,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_bytes,
    output logic                 busy
`ifdef LZSS_FRAME_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]     ref_tokens,
    output logic [CNT_W-1:0]     lit_tokens,
    output logic                 overflow
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DW  = $clog2(PIPE_LAT + 2);
    localparam int TW  = WORD_SIZE + 1;
    localparam int LIM = FIFO_DEPTH - PIPE_LAT - 1;
    localparam int DE  = PIPE_LAT + 1;

    localparam logic [CW-1:0] LIM_C     = LIM[CW-1:0];
    localparam logic [CW-1:0] DEPTH_C   = FIFO_DEPTH[CW-1:0];
    localparam logic [DW-1:0] DRAIN_END = DE[DW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 enc_rst_n_q, enc_rst_n_d;
    logic                 enc_rst_n_prev_q;
    logic                 enc_w_en_q, enc_w_en_d;
    logic [WORD_SIZE-1:0] enc_data_q, enc_data_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]     frame_bytes_q, frame_bytes_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;

    logic [TW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic                 full;

    // Credit check uses the registered count so s_ready has no path from m_ready.
    assign s_ready = (state_q == S_STREAM) && (cnt_q < LIM_C);
    assign accept  = s_valid && s_ready;

    assign enc_rst_n   = enc_rst_n_q;
    assign enc_w_en    = enc_w_en_q;
    assign enc_data    = enc_data_q;
    assign frame_done  = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign busy        = busy_q;
    assign m_valid     = (cnt_q != '0);
    assign m_tok       = mem_q[rd_ptr_q];

    // Frame sequencing: next state plus the registered encoder controls.
    always_comb begin
        state_d       = state_q;
        enc_w_en_d    = 1'b0;
        enc_data_d    = enc_data_q;
        drain_d       = drain_q;
        byte_cnt_d    = byte_cnt_q;
        frame_bytes_d = frame_bytes_q;
        unique case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept) begin
                    enc_w_en_d = 1'b1;
                    enc_data_d = s_data;
                    if (byte_cnt_q != '1) begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_END) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        enc_rst_n_d  = (state_d == S_STREAM) ||
                       (state_d == S_DRAIN)  ||
                       (state_d == S_DONE);
        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        if (frame_done_d) begin
            frame_bytes_d = byte_cnt_d;
            byte_cnt_d    = '0;
        end
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            enc_rst_n_q      <= 1'b0;
            enc_rst_n_prev_q <= 1'b0;
            enc_w_en_q       <= 1'b0;
            enc_data_q       <= '0;
            drain_q          <= '0;
            byte_cnt_q       <= '0;
            frame_bytes_q    <= '0;
            frame_done_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            enc_rst_n_q      <= enc_rst_n_d;
            enc_rst_n_prev_q <= enc_rst_n_q;
            enc_w_en_q       <= enc_w_en_d;
            enc_data_q       <= enc_data_d;
            drain_q          <= drain_d;
            byte_cnt_q       <= byte_cnt_d;
            frame_bytes_q    <= frame_bytes_d;
            frame_done_q     <= frame_done_d;
            busy_q           <= busy_d;
        end
    end

    // Token FIFO control; tokens seen while the encoder was held in clear are ignored.
    always_comb begin
        push_req = enc_tok_vld && enc_rst_n_prev_q;
        pop      = m_valid && m_ready;
        full     = (cnt_q == DEPTH_C);
        push     = push_req && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; stale entries are masked by the pointers after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_tok;
        end
    end

`ifdef LZSS_FRAME_CTRL_STATS_EN
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] lit_cnt_q, lit_cnt_d;
    logic [CNT_W-1:0] ref_tok_q, ref_tok_d;
    logic [CNT_W-1:0] lit_tok_q, lit_tok_d;
    logic             ovf_q, ovf_d;

    assign ref_tokens = ref_tok_q;
    assign lit_tokens = lit_tok_q;
    assign overflow   = ovf_q;

    // Per-frame token classification, latched together with frame_bytes.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        lit_cnt_d = lit_cnt_q;
        ref_tok_d = ref_tok_q;
        lit_tok_d = lit_tok_q;
        ovf_d     = ovf_q || (push_req && full && !pop);
        if (push) begin
            if (enc_tok[WORD_SIZE]) begin
                if (ref_cnt_q != '1) begin
                    ref_cnt_d = ref_cnt_q + CNT_W'(1);
                end
            end else begin
                if (lit_cnt_q != '1) begin
                    lit_cnt_d = lit_cnt_q + CNT_W'(1);
                end
            end
        end
        if (frame_done_d) begin
            ref_tok_d = ref_cnt_d;
            lit_tok_d = lit_cnt_d;
            ref_cnt_d = '0;
            lit_cnt_d = '0;
        end
    end

    // Statistics registers; overflow stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            lit_cnt_q <= '0;
            ref_tok_q <= '0;
            lit_tok_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            lit_cnt_q <= lit_cnt_d;
            ref_tok_q <= ref_tok_d;
            lit_tok_q <= lit_tok_d;
            ovf_q     <= ovf_d;
        end
    end
`endif

endmodule
